spi_3wire_reg_slave: RTL

Responder end of the 3-wire ADC configuration SPI: a register-file target that decodes the same instruction/data frames our ADC configuration master issues and answers reads on the shared SDIO line. It is used in the loopback/self-test build and in simulation as the stand-in for the external 8-bit ADC, so the configuration master can be exercised end-to-end. All SPI inputs are oversampled in the `clk` domain; nothing is clocked by `spi_sclk`.

---
 rtl/spi_3wire_reg_slave_if.sv | 11 +
 rtl/spi_3wire_reg_slave.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/spi_3wire_reg_slave_if.sv
// 3-wire SPI pin bundle between the configuration master and the register-file responder.
interface spi_3wire_reg_slave_if;
  logic spi_ce;
  logic spi_sclk;
  logic spi_sdi;
  logic spi_sdo;
  logic spi_sdo_oe;

  modport master (output spi_ce, spi_sclk, spi_sdi, input spi_sdo, spi_sdo_oe);
  modport slave  (input spi_ce, spi_sclk, spi_sdi, output spi_sdo, spi_sdo_oe);
endinterface

// File: rtl/spi_3wire_reg_slave.sv
// 3-wire SPI register-file responder; stand-in for the external 8-bit ADC config port.
// All SPI pins are oversampled in clk; spi_sclk only feeds the edge detector.
module spi_3wire_reg_slave #(
  parameter int          ADDR_W      = 6,
  parameter logic [12:0] STATUS_ADDR = 13'h1F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_2byte,
  spi_3wire_reg_slave_if.slave spi,
  input  logic [7:0]        status_in,
  output logic              wr_valid,
  output logic [12:0]       wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_INSTR, S_WDATA, S_RDATA, S_DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  ce_s, sclk_s, sdi_s;
  logic        sclk_d;
  logic        ce_n, sdi_q, rise, fall;
  logic [4:0]  cnt;
  logic [14:0] sh;
  logic [15:0] iw;
  logic [4:0]  ilen;
  logic        i_rw;
  logic [12:0] i_addr, a_q;
  logic [7:0]  rsel, sdo_sh;
  logic        instr_done, commit;
  logic [7:0]  mem [2**ADDR_W];
  logic        unused_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_s   <= 2'b11;
      sclk_s <= 2'b00;
      sdi_s  <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      ce_s   <= {ce_s[0], spi.spi_ce};
      sclk_s <= {sclk_s[0], spi.spi_sclk};
      sdi_s  <= {sdi_s[0], spi.spi_sdi};
      sclk_d <= sclk_s[1];
    end
  end

  assign ce_n  = ce_s[1];
  assign sdi_q = sdi_s[1];
  assign rise  = sclk_s[1] & ~sclk_d;
  assign fall  = ~sclk_s[1] & sclk_d;

  // Word as it will look once the current rise has been shifted in.
  assign iw          = {sh, sdi_q};
  assign ilen        = addr_2byte ? 5'd16 : 5'd8;
  assign i_rw        = addr_2byte ? iw[15] : iw[7];
  assign i_addr      = addr_2byte ? iw[12:0] : {6'b0, iw[6:0]};
  assign unused_bits = ^iw[14:13];

  always_comb begin
    rsel = 8'h00;
    if (i_addr == STATUS_ADDR)       rsel = status_in;
    else if (i_addr[12:ADDR_W] == '0) rsel = mem[i_addr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // CE release has priority over every in-frame event, including the last-bit commit.
  always_comb begin
    state_n    = state;
    instr_done = 1'b0;
    commit     = 1'b0;
    if (ce_n) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  state_n = S_INSTR;
        S_INSTR: if (rise && (cnt + 5'd1 == ilen)) begin
          instr_done = 1'b1;
          state_n    = i_rw ? S_RDATA : S_WDATA;
        end
        S_WDATA: if (rise && cnt == 5'd7) begin
          commit  = 1'b1;
          state_n = S_DONE;
        end
        S_RDATA: if (rise && cnt == 5'd8) state_n = S_DONE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      sh             <= '0;
      a_q            <= '0;
      sdo_sh         <= '0;
      spi.spi_sdo    <= 1'b0;
      spi.spi_sdo_oe <= 1'b0;
      wr_valid       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (ce_n) begin
        spi.spi_sdo    <= 1'b0;
        spi.spi_sdo_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            sh  <= '0;
          end
          S_INSTR: if (rise) begin
            sh  <= iw[14:0];
            cnt <= cnt + 5'd1;
            if (instr_done) begin
              cnt    <= '0;
              a_q    <= i_addr;
              sdo_sh <= rsel;
            end
          end
          S_WDATA: if (rise) begin
            sh  <= iw[14:0];
            cnt <= cnt + 5'd1;
            if (commit) begin
              wr_valid <= 1'b1;
              wr_addr  <= a_q;
              wr_data  <= iw[7:0];
              if (a_q[12:ADDR_W] == '0 && a_q != STATUS_ADDR)
                mem[a_q[ADDR_W-1:0]] <= iw[7:0];
            end
          end
          S_RDATA: if (fall && cnt < 5'd8) begin
            spi.spi_sdo_oe <= 1'b1;
            spi.spi_sdo    <= sdo_sh[7];
            sdo_sh         <= {sdo_sh[6:0], 1'b0};
            cnt            <= cnt + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data = mem[rd_addr];
  assign busy    = (state != S_IDLE);

endmodule
